// File: rtl/demux4_stream.sv
// 1->4 stream demultiplexer. Each accepted word is routed by sel into a one-entry
// output register, and each channel keeps a saturating count of delivered words.
module demux4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   d,
  input  logic [1:0]         sel,
  input  logic               d_valid,
  output logic               d_ready,
  output logic [WIDTH-1:0]   z0,
  output logic [WIDTH-1:0]   z1,
  output logic [WIDTH-1:0]   z2,
  output logic [WIDTH-1:0]   z3,
  output logic [3:0]         z_valid,
  input  logic [3:0]         z_ready,
  output logic [4*CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0][WIDTH-1:0] z_q;
  logic [3:0]            take;
  logic [3:0]            load;
  logic                  acc;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    load    = '0;
    // A full channel still accepts when its consumer drains it in the same cycle.
    d_ready = !rst && (!z_valid[sel] || z_ready[sel]);
    acc     = d_valid && d_ready;
    take    = z_valid & z_ready;
    if (acc) load[sel] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset as well, since z0..z3 must read 0 after reset.
      z_valid <= '0;
      z_q     <= '0;
      cnt     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          z_q[i]     <= d;
          z_valid[i] <= 1'b1;
        end else if (take[i]) begin
          z_valid[i] <= 1'b0;
        end
        if (take[i] && (cnt[i*CNT_W +: CNT_W] != CNT_MAX))
          cnt[i*CNT_W +: CNT_W] <= cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign z0 = z_q[0];
  assign z1 = z_q[1];
  assign z2 = z_q[2];
  assign z3 = z_q[3];

endmodule
